// File: rtl/pipe_id_operand_pkg.sv
// Shared definitions for the decode-stage operand unit.
// ALU-control encodings, forward-select enumeration and default widths
// used by pipe_id_operand and pipe_fwd_sel.
package pipe_id_operand_pkg;

  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned RW_DEF  = 5;
  localparam int unsigned SCW_DEF = 16;
  localparam int unsigned ALUC_W  = 4;

  localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/pipe_id_operand_fwd_sel.sv
// pipe_fwd_sel: combinational forwarding priority mux for one source operand.
// Ports:
//   rn                 source register number
//   q                  register-file read data for rn
//   evalid/ewreg/em2reg/ewn/ealu   EX-stage producer
//   mwreg/mm2reg/mwn/malu/mmo      MEM-stage producer
//   wwreg/wwn/wdi                  WB-stage producer
//   fwd                resolved operand value
// Priority: r0 -> EX -> MEM -> WB -> register file.
module pipe_fwd_sel
  import pipe_id_operand_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RW     = RW_DEF,
  parameter int unsigned WB_FWD = 1
) (
  input  logic [RW-1:0] rn,
  input  logic [DW-1:0] q,
  input  logic          evalid,
  input  logic          ewreg,
  input  logic          em2reg,
  input  logic [RW-1:0] ewn,
  input  logic [DW-1:0] ealu,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic [RW-1:0] mwn,
  input  logic [DW-1:0] malu,
  input  logic [DW-1:0] mmo,
  input  logic          wwreg,
  input  logic [RW-1:0] wwn,
  input  logic [DW-1:0] wdi,
  output logic [DW-1:0] fwd
);

  logic     ex_hit;
  logic     mem_hit;
  logic     wb_hit;
  fwd_sel_e sel;

  always_comb begin
    // A load in EX has no data yet; that case is handled by the stall.
    ex_hit  = evalid & ewreg & ~em2reg & (ewn == rn);
    mem_hit = mwreg & (mwn == rn);
    // The register file writes on the clock edge, so a same-cycle read of
    // the WB destination returns the old value.
    wb_hit  = (WB_FWD != 0) & wwreg & (wwn == rn);

    if (ex_hit)       sel = FWD_EX;
    else if (mem_hit) sel = FWD_MEM;
    else if (wb_hit)  sel = FWD_WB;
    else              sel = FWD_RF;

    unique case (sel)
      FWD_EX:  fwd = ealu;
      FWD_MEM: fwd = mm2reg ? mmo : malu;
      FWD_WB:  fwd = wdi;
      default: fwd = q;
    endcase

    // r0 is hard-wired to zero regardless of any producer claiming it.
    if (rn == '0) fwd = '0;
  end

endmodule

// File: rtl/pipe_id_operand.sv
// pipe_id_operand: decode-stage operand resolution and ID/EX register.
// Inputs:  register numbers and register-file data (rna/rnb/qa/qb), operand
//          usage flags, ID control (dvalid, dflush, dwreg, dm2reg, dwn,
//          daluc, daluimm, dimm) and EX/MEM/WB producer information.
// Outputs: wpcir (0 = stall PC and IF/ID), EX-stage registers (evalid,
//          ewreg, em2reg, ewn, ealuc, ea, eb) and a saturating load-use
//          stall counter (estall_cnt).
module pipe_id_operand
  import pipe_id_operand_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RW     = RW_DEF,
  parameter int unsigned WB_FWD = 1,
  parameter int unsigned SCW    = SCW_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [RW-1:0]     rna,
  input  logic [RW-1:0]     rnb,
  input  logic [DW-1:0]     qa,
  input  logic [DW-1:0]     qb,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              dvalid,
  input  logic              dflush,
  input  logic              dwreg,
  input  logic              dm2reg,
  input  logic [RW-1:0]     dwn,
  input  logic [ALUC_W-1:0] daluc,
  input  logic              daluimm,
  input  logic [DW-1:0]     dimm,
  input  logic [DW-1:0]     ealu,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [RW-1:0]     mwn,
  input  logic [DW-1:0]     malu,
  input  logic [DW-1:0]     mmo,
  input  logic              wwreg,
  input  logic [RW-1:0]     wwn,
  input  logic [DW-1:0]     wdi,
  output logic              wpcir,
  output logic              evalid,
  output logic              ewreg,
  output logic              em2reg,
  output logic [RW-1:0]     ewn,
  output logic [ALUC_W-1:0] ealuc,
  output logic [DW-1:0]     ea,
  output logic [DW-1:0]     eb,
  output logic [SCW-1:0]    estall_cnt
);

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic          stall;
  logic          bubble;

  pipe_fwd_sel #(.DW(DW), .RW(RW), .WB_FWD(WB_FWD)) u_fwd_a (
    .rn(rna), .q(qa),
    .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg), .ewn(ewn), .ealu(ealu),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwn(mwn), .malu(malu), .mmo(mmo),
    .wwreg(wwreg), .wwn(wwn), .wdi(wdi),
    .fwd(fwd_a)
  );

  pipe_fwd_sel #(.DW(DW), .RW(RW), .WB_FWD(WB_FWD)) u_fwd_b (
    .rn(rnb), .q(qb),
    .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg), .ewn(ewn), .ealu(ealu),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwn(mwn), .malu(malu), .mmo(mmo),
    .wwreg(wwreg), .wwn(wwn), .wdi(wdi),
    .fwd(fwd_b)
  );

  always_comb begin
    // Load in EX whose destination is read here: data only exists in MEM
    // next cycle, so hold ID one cycle and insert a bubble.
    stall  = dvalid & evalid & ewreg & em2reg & (ewn != '0) &
             ((use_rs & (ewn == rna)) | (use_rt & (ewn == rnb)));
    wpcir  = ~stall;
    bubble = stall | dflush | ~dvalid;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      evalid     <= 1'b0;
      ewreg      <= 1'b0;
      em2reg     <= 1'b0;
      ewn        <= '0;
      ealuc      <= '0;
      ea         <= '0;
      eb         <= '0;
      estall_cnt <= '0;
    end else begin
      evalid <= ~bubble;
      ewreg  <= ~bubble & dwreg;
      em2reg <= ~bubble & dm2reg;
      // Data fields load unconditionally; a bubble makes them don't-care.
      ewn    <= dwn;
      ealuc  <= daluc;
      ea     <= fwd_a;
      eb     <= daluimm ? dimm : fwd_b;
      if (stall && (estall_cnt != '1)) estall_cnt <= estall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_id_operand.sv
module tb_pipe_id_operand;
  localparam int DW  = 32;
  localparam int RW  = 5;
  // Narrow counter so saturation is reachable within a short run.
  localparam int SCW = 10;
  localparam logic [SCW-1:0] CNT_MAX = {SCW{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clrn;
  logic [RW-1:0] rna, rnb, dwn, mwn, wwn, ewn;
  logic [DW-1:0] qa, qb, dimm, ealu, malu, mmo, wdi, ea, eb;
  logic use_rs, use_rt, dvalid, dflush, dwreg, dm2reg, daluimm;
  logic [3:0] daluc, ealuc;
  logic mwreg, mm2reg, wwreg;
  logic wpcir, evalid, ewreg, em2reg;
  logic [SCW-1:0] estall_cnt;

  pipe_id_operand #(.DW(DW), .RW(RW), .WB_FWD(1), .SCW(SCW)) dut (
    .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .use_rs(use_rs), .use_rt(use_rt), .dvalid(dvalid), .dflush(dflush),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwn(dwn), .daluc(daluc),
    .daluimm(daluimm), .dimm(dimm), .ealu(ealu), .mwreg(mwreg),
    .mm2reg(mm2reg), .mwn(mwn), .malu(malu), .mmo(mmo), .wwreg(wwreg),
    .wwn(wwn), .wdi(wdi), .wpcir(wpcir), .evalid(evalid), .ewreg(ewreg),
    .em2reg(em2reg), .ewn(ewn), .ealuc(ealuc), .ea(ea), .eb(eb),
    .estall_cnt(estall_cnt)
  );

  typedef struct {
    string          tag;
    logic           v, w, m;
    logic [RW-1:0]  wn;
    logic [3:0]     aluc;
    logic [DW-1:0]  a, b;
    logic [SCW-1:0] cnt;
    bit             chk_data;
  } exp_t;

  exp_t sb[$];
  int ncmp  = 0;
  int nfail = 0;

  task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input bit v, input bit w, input bit m,
                      input logic [RW-1:0] wn, input logic [3:0] aluc,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [SCW-1:0] cnt, input bit chk_data);
    exp_t e;
    e.tag = tag; e.v = v; e.w = w; e.m = m; e.wn = wn; e.aluc = aluc;
    e.a = a; e.b = b; e.cnt = cnt; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  // Clock one edge, then pop the scoreboard entry for that edge and compare.
  task automatic clock_check();
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      cmp("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".evalid"}, evalid, e.v);
      cmp({e.tag, ".ewreg"}, ewreg, e.w);
      cmp({e.tag, ".em2reg"}, em2reg, e.m);
      cmp({e.tag, ".cnt"}, estall_cnt, e.cnt);
      if (e.chk_data) begin
        cmp({e.tag, ".ewn"}, ewn, e.wn);
        cmp({e.tag, ".ealuc"}, ealuc, e.aluc);
        cmp({e.tag, ".ea"}, ea, e.a);
        cmp({e.tag, ".eb"}, eb, e.b);
      end
    end
  endtask

  task automatic id(input bit valid, input bit flush, input bit wreg, input bit m2reg,
                    input logic [RW-1:0] wn, input logic [3:0] aluc,
                    input bit aluimm, input logic [DW-1:0] imm,
                    input logic [RW-1:0] ra, input logic [RW-1:0] rb,
                    input logic [DW-1:0] a, input logic [DW-1:0] b,
                    input bit urs, input bit urt);
    dvalid = valid; dflush = flush; dwreg = wreg; dm2reg = m2reg; dwn = wn;
    daluc = aluc; daluimm = aluimm; dimm = imm; rna = ra; rnb = rb;
    qa = a; qb = b; use_rs = urs; use_rt = urt;
  endtask

  task automatic mem(input bit wreg, input bit m2reg, input logic [RW-1:0] wn,
                     input logic [DW-1:0] alu, input logic [DW-1:0] mo);
    mwreg = wreg; mm2reg = m2reg; mwn = wn; malu = alu; mmo = mo;
  endtask

  task automatic wb(input bit wreg, input logic [RW-1:0] wn, input logic [DW-1:0] di);
    wwreg = wreg; wwn = wn; wdi = di;
  endtask

  initial begin
    clrn = 1'b0;
    id(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    ealu = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp("rst.evalid", evalid, 1'b0);
    cmp("rst.ewreg", ewreg, 1'b0);
    cmp("rst.ea", ea, 32'd0);
    cmp("rst.cnt", estall_cnt, '0);
    cmp("rst.wpcir", wpcir, 1'b1);
    clrn = 1'b1;

    // S1: plain add r3 = r1 + r2, no producers
    id(1, 0, 1, 0, 5'd3, 4'h0, 0, 0, 5'd1, 5'd2, 32'd10, 32'd20, 1, 1);
    push("s1_add", 1, 1, 0, 5'd3, 4'h0, 32'd10, 32'd20, 0, 1);
    clock_check();

    // S2: sub reads r3 produced in EX (ealu=5), regfile stale 0
    ealu = 32'd5;
    id(1, 0, 1, 0, 5'd6, 4'h1, 0, 0, 5'd3, 5'd2, 32'd0, 32'd20, 1, 1);
    push("s2_fwd_ex", 1, 1, 0, 5'd6, 4'h1, 32'd5, 32'd20, 0, 1);
    clock_check();

    // S3: r3 produced in MEM (malu)
    ealu = 32'h777;
    mem(1, 0, 5'd3, 32'h11, 32'h0);
    id(1, 0, 0, 0, 5'd0, 4'h2, 0, 0, 5'd3, 5'd2, 32'd0, 32'd20, 1, 1);
    push("s3_fwd_mem", 1, 0, 0, 5'd0, 4'h2, 32'h11, 32'd20, 0, 1);
    clock_check();

    // S4: r3 produced in WB, regfile stale; B operand is immediate
    mem(0, 0, 0, 0, 0);
    wb(1, 5'd3, 32'h22);
    id(1, 0, 1, 0, 5'd3, 4'h3, 1, 32'h1234, 5'd3, 5'd2, 32'd0, 32'd20, 1, 1);
    push("s4_fwd_wb_imm", 1, 1, 0, 5'd3, 4'h3, 32'h22, 32'h1234, 0, 1);
    clock_check();

    // S5: r3 in EX (7) and MEM (9) -> EX wins; instruction is lw r4
    wb(0, 0, 0);
    ealu = 32'd7;
    mem(1, 0, 5'd3, 32'd9, 32'd0);
    id(1, 0, 1, 1, 5'd4, 4'h0, 0, 0, 5'd3, 5'd3, 32'd0, 32'd0, 1, 1);
    #1 cmp("s5.wpcir", wpcir, 1'b1);
    push("s5_ex_prio", 1, 1, 1, 5'd4, 4'h0, 32'd7, 32'd7, 0, 1);
    clock_check();

    // S6: add uses rt=r4 while lw r4 is in EX -> stall, bubble
    mem(0, 0, 0, 0, 0);
    ealu = '0;
    id(1, 0, 1, 0, 5'd8, 4'h0, 0, 0, 5'd1, 5'd4, 32'd10, 32'd0, 1, 1);
    #1 cmp("s6.wpcir", wpcir, 1'b0);
    push("s6_loaduse", 0, 0, 0, 5'd0, 4'h0, 32'd0, 32'd0, 1, 0);
    clock_check();

    // S7: re-presented instruction takes r4 from mmo; it is lw r0
    mem(1, 1, 5'd4, 32'h1111, 32'hDEADBEEF);
    id(1, 0, 1, 1, 5'd0, 4'h0, 0, 0, 5'd1, 5'd4, 32'd10, 32'd0, 1, 1);
    #1 cmp("s7.wpcir", wpcir, 1'b1);
    push("s7_fwd_mmo", 1, 1, 1, 5'd0, 4'h0, 32'd10, 32'hDEADBEEF, 1, 1);
    clock_check();

    // S8: reads r0 with lw r0 in EX and MEM writing r0 -> 0, no stall
    mem(1, 0, 5'd0, 32'h66, 32'h0);
    ealu = 32'h55;
    id(1, 0, 1, 0, 5'd0, 4'h0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0, 1, 1);
    #1 cmp("s8.wpcir", wpcir, 1'b1);
    push("s8_r0_load", 1, 1, 0, 5'd0, 4'h0, 32'd0, 32'd0, 1, 1);
    clock_check();

    // S9: non-load in EX writing r0 = 0x55 -> still 0; instruction is lw r5
    mem(0, 0, 0, 0, 0);
    id(1, 0, 1, 1, 5'd5, 4'h0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0, 1, 1);
    push("s9_r0_ex", 1, 1, 1, 5'd5, 4'h0, 32'd0, 32'd0, 1, 1);
    clock_check();

    // S10: flush together with load-use stall -> bubble, counter counts
    ealu = '0;
    id(1, 1, 1, 0, 5'd9, 4'h0, 0, 0, 5'd5, 5'd0, 32'd0, 32'd0, 1, 0);
    #1 cmp("s10.wpcir", wpcir, 1'b0);
    push("s10_flush_stall", 0, 0, 0, 5'd0, 4'h0, 32'd0, 32'd0, 2, 0);
    clock_check();

    // S11: no valid instruction -> bubble
    id(0, 0, 1, 0, 5'd9, 4'h0, 0, 0, 5'd5, 5'd0, 32'd0, 32'd0, 1, 0);
    push("s11_invalid", 0, 0, 0, 5'd0, 4'h0, 32'd0, 32'd0, 2, 0);
    clock_check();

    // S12: lw r7
    id(1, 0, 1, 1, 5'd7, 4'h0, 0, 0, 5'd1, 5'd2, 32'd10, 32'd20, 0, 0);
    push("s12_lw", 1, 1, 1, 5'd7, 4'h0, 32'd10, 32'd20, 2, 1);
    clock_check();

    // Reset asserted mid-stall
    id(1, 0, 1, 0, 5'd8, 4'h0, 0, 0, 5'd7, 5'd2, 32'd0, 32'd20, 1, 1);
    #1 cmp("midrst.pre_wpcir", wpcir, 1'b0);
    clrn = 1'b0;
    #1;
    cmp("midrst.evalid", evalid, 1'b0);
    cmp("midrst.em2reg", em2reg, 1'b0);
    cmp("midrst.ewn", ewn, 5'd0);
    cmp("midrst.eb", eb, 32'd0);
    cmp("midrst.cnt", estall_cnt, '0);
    cmp("midrst.wpcir", wpcir, 1'b1);
    @(posedge clk); #1;
    clrn = 1'b1;
    id(1, 0, 1, 0, 5'd3, 4'h0, 0, 0, 5'd1, 5'd2, 32'd10, 32'd20, 1, 1);
    #1 cmp("postrst.wpcir", wpcir, 1'b1);
    push("postrst_add", 1, 1, 0, 5'd3, 4'h0, 32'd10, 32'd20, 0, 1);
    clock_check();

    // Saturation: alternate lw r7 / consumer of r7, one stall per pair
    for (int i = 0; i < int'(CNT_MAX) + 5; i++) begin
      id(1, 0, 1, 1, 5'd7, 4'h0, 0, 0, 5'd1, 5'd2, 32'd10, 32'd20, 0, 0);
      @(posedge clk); #1;
      id(1, 0, 1, 0, 5'd8, 4'h0, 0, 0, 5'd7, 5'd2, 32'd0, 32'd20, 1, 1);
      @(posedge clk); #1;
      if (i == int'(CNT_MAX) - 1) cmp("sat.reach_max", estall_cnt, CNT_MAX);
    end
    cmp("sat.hold_max", estall_cnt, CNT_MAX);
    cmp("sb.drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/pipe_id_operand.md
Name: pipe_id_operand

Overview:
- Decode-stage operand unit and ID/EX pipeline register for the 5-stage pipelined CPU.
- Consumes the two combinational read ports of the register file (rna/rnb -> qa/qb).
- Resolves RAW hazards by forwarding from EX, MEM and WB, and detects load-use hazards, issuing a stall.
- Latches the resolved operands plus control into the EX-stage registers each cycle.

Parameters:
- DW, 32, datapath width
- RW, 5, register-number width
- WB_FWD, 1, 1 = forward the WB-stage write value (register file writes on posedge, so same-cycle reads see stale data); 0 = no WB forwarding
- SCW, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock, all state on posedge
- clrn  in  1  asynchronous active-low reset
- rna  in  RW  rs number (also drives register-file port A)
- rnb  in  RW  rt number (also drives register-file port B)
- qa  in  DW  register-file read data A
- qb  in  DW  register-file read data B
- use_rs  in  1  instruction reads rs
- use_rt  in  1  instruction reads rt
- dvalid  in  1  ID holds a real instruction
- dflush  in  1  squash ID instruction (taken branch/jump)
- dwreg  in  1  instruction writes a register
- dm2reg  in  1  instruction is a load
- dwn  in  RW  destination register
- daluc  in  4  ALU control
- daluimm  in  1  B operand is the immediate
- dimm  in  DW  extended immediate
- ealu  in  DW  EX-stage ALU result (combinational)
- mwreg  in  1  MEM-stage writes a register
- mm2reg  in  1  MEM-stage is a load
- mwn  in  RW  MEM-stage destination
- malu  in  DW  MEM-stage ALU result
- mmo  in  DW  MEM-stage load data
- wwreg  in  1  WB write enable (same net as register-file we)
- wwn  in  RW  WB destination (register-file wn)
- wdi  in  DW  WB data (register-file d)
- wpcir  out  1  0 = hold PC and IF/ID (stall)
- evalid  out  1  EX-stage valid
- ewreg  out  1  EX writes a register
- em2reg  out  1  EX is a load
- ewn  out  RW  EX destination
- ealuc  out  4  EX ALU control
- ea  out  DW  EX operand A
- eb  out  DW  EX operand B, already muxed with the immediate
- estall_cnt  out  SCW  saturating count of load-use stall cycles

Behaviour:
- Reset (clrn=0, asynchronous): evalid, ewreg, em2reg = 0; ewn, ealuc, ea, eb = 0; estall_cnt = 0. wpcir is combinational and reads 1 under reset.
- Forward select per source operand (rs shown; rt identical). First match wins:
  - rna == 0 -> 0 (r0 is never forwarded).
  - EX: evalid & ewreg & !em2reg & ewn == rna -> ealu.
  - MEM: mwreg & mwn == rna -> mm2reg ? mmo : malu.
  - WB: WB_FWD & wwreg & wwn == rna -> wdi.
  - Otherwise -> qa.
- Load-use stall: stall = dvalid & evalid & ewreg & em2reg & ewn != 0 & ((use_rs & ewn == rna) | (use_rt & ewn == rnb)). wpcir = !stall.
- Posedge update:
  - If stall or dflush or !dvalid: insert a bubble (evalid, ewreg, em2reg = 0). ea, eb and ewn may update but are don't-care.
  - Else: latch all d* control, ea = fwdA, eb = daluimm ? dimm : fwdB.
- Latency: one cycle from ID to EX registers. A stalled instruction re-presents in ID next cycle and then forwards from MEM via mmo. A load-use stall therefore lasts exactly 1 cycle.
- Simultaneous dflush and stall: flush dominates (bubble). wpcir still follows stall; the upstream owner ignores it on flush.
- estall_cnt increments once per stall cycle and saturates at 2^SCW-1, with no wrap.
- Reset asserted mid-stall clears the bubble state; the first cycle after release always has wpcir = 1.

Decomposition:
- Shared package: ALU-control encodings, forward-select enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), register-width constants.
- One natural sub-module, pipe_fwd_sel, instantiated twice (rs and rt): combinational priority mux plus match flags.

Test Plan:
- Reset with clrn=0 mid-stream -> all e* outputs 0, estall_cnt 0, wpcir 1. Release -> a normal add latches next edge.
- add r3=5 in EX, sub reads r3 -> ea = ealu = 5. Same with the producer in MEM -> malu. Producer in WB with regfile qa stale 0 -> ea = wdi.
- r3 written in both EX (7) and MEM (9), consumer reads r3 -> ea = 7 (EX priority).
- lw r4 in EX, add uses rt=r4 -> wpcir 0 for one cycle, bubble (evalid 0), estall_cnt 1. Next cycle eb = mmo = 0xDEADBEEF.
- Instruction reads r0 while EX writes r0 = 0x55 -> ea = 0, no stall even if the EX instruction is a load.
- dflush together with a load-use stall -> bubble, estall_cnt still increments. Force 65535 stalls -> counter holds at 0xFFFF.
